// File: rtl/cruise_pkg.sv
// Shared cruise-control types and default limits, also
// reused by the speed display and throttle-actuator stages.
package cruise_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      CRUISE = 1'b1
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam logic [7:0] DEF_MAX_SPEED   = 8'd200;
   localparam logic [7:0] DEF_MIN_CRUISE  = 8'd30;
   localparam logic [7:0] DEF_ACCEL_STEP  = 8'd2;
   localparam logic [7:0] DEF_BRAKE_STEP  = 8'd4;
   localparam logic [7:0] DEF_CRUISE_STEP = 8'd5;
   localparam int         DEF_COAST_DIV   = 8;

   // Target nudge, clamped to [lo, hi] without touching the adder.
   function automatic logic [7:0] step_target(
      input logic [7:0] t,
      input logic       up,
      input logic [7:0] step,
      input logic [7:0] lo,
      input logic [7:0] hi
   );
      logic [8:0] s;
      logic [7:0] r;
      if (up) begin
         s = {1'b0, t} + {1'b0, step};
         r = (s > {1'b0, hi}) ? hi : s[7:0];
      end else begin
         s = {1'b0, lo} + {1'b0, step};
         r = ({1'b0, t} < s) ? lo : t - step;
      end
      return r;
   endfunction

endpackage

// File: rtl/cruise_speed_regulator_if.sv
// Operand/result bus between the regulator and the shared
// 8-bit adder/subtractor.
interface cruise_speed_regulator_if;

   logic [7:0] add_a;
   logic [7:0] add_b;
   logic       add_sel;
   logic       add_en;
   logic [7:0] add_s;
   logic       add_cout;

   modport master (
      output add_a,
      output add_b,
      output add_sel,
      output add_en,
      input  add_s,
      input  add_cout
   );

   modport slave (
      input  add_a,
      input  add_b,
      input  add_sel,
      input  add_en,
      output add_s,
      output add_cout
   );

endinterface

// File: rtl/cruise_sat_unit.sv
// Clamps the raw adder/subtractor result into the legal
// speed range [0, max_speed].
import cruise_pkg::*;

module cruise_sat_unit (
   input  logic [7:0] add_s,
   input  logic       add_cout,
   input  logic       add_sel,
   input  logic [7:0] max_speed,
   output logic [7:0] sat_s
);

   always_comb begin
      sat_s = add_s;
      if (add_sel == OP_ADD) begin
         if (add_cout || (add_s > max_speed))
            sat_s = max_speed;
      end else if (!add_cout) begin
         // carry-out low on subtract is a borrow
         sat_s = '0;
      end
   end

endmodule

// File: rtl/cruise_speed_regulator.sv
// Speed/cruise controller: picks one speed op per cycle,
// drives the external adder and registers the clamped result.
import cruise_pkg::*;

module cruise_speed_regulator #(
   parameter logic [7:0] MAX_SPEED   = DEF_MAX_SPEED,
   parameter logic [7:0] MIN_CRUISE  = DEF_MIN_CRUISE,
   parameter logic [7:0] ACCEL_STEP  = DEF_ACCEL_STEP,
   parameter logic [7:0] BRAKE_STEP  = DEF_BRAKE_STEP,
   parameter logic [7:0] CRUISE_STEP = DEF_CRUISE_STEP,
   parameter int         COAST_DIV   = DEF_COAST_DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       throttle,
   input  logic       brake,
   input  logic       cruise_set,
   input  logic       cruise_off,
   input  logic       cruise_up,
   input  logic       cruise_down,
   cruise_speed_regulator_if.master adder,
   output logic [7:0] speed,
   output logic [7:0] target,
   output logic       cruising
);

   localparam int CW = (COAST_DIV > 1) ? $clog2(COAST_DIV) : 1;
   localparam logic [CW-1:0] COAST_LAST = CW'(COAST_DIV - 1);

   state_t        state_q, state_d;
   logic [7:0]    speed_q, speed_d;
   logic [7:0]    target_q, target_d;
   logic [CW-1:0] coast_q, coast_d;

   logic       op_en;
   logic       op_sel;
   logic [7:0] op_b;
   logic [7:0] sat_s;
   logic       pedal;

   assign pedal = brake | throttle;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         speed_q  <= '0;
         target_q <= '0;
         coast_q  <= '0;
      end else begin
         state_q  <= state_d;
         speed_q  <= speed_d;
         target_q <= target_d;
         coast_q  <= coast_d;
      end
   end

   // Speed operation select, strict priority.
   always_comb begin
      op_en  = 1'b0;
      op_sel = OP_ADD;
      op_b   = '0;
      if (rst_n) begin
         if (brake) begin
            op_en  = 1'b1;
            op_sel = OP_SUB;
            op_b   = BRAKE_STEP;
         end else if (throttle) begin
            op_en  = 1'b1;
            op_sel = OP_ADD;
            op_b   = ACCEL_STEP;
         end else if (state_q == CRUISE) begin
            unique case (1'b1)
               (speed_q < target_q): begin
                  op_en  = 1'b1;
                  op_sel = OP_ADD;
                  op_b   = 8'd1;
               end
               (speed_q > target_q): begin
                  op_en  = 1'b1;
                  op_sel = OP_SUB;
                  op_b   = 8'd1;
               end
               default: ;
            endcase
         end else if (coast_q == COAST_LAST) begin
            op_en  = 1'b1;
            op_sel = OP_SUB;
            op_b   = 8'd1;
         end
      end
   end

   cruise_sat_unit u_sat (
      .add_s     (adder.add_s),
      .add_cout  (adder.add_cout),
      .add_sel   (op_sel),
      .max_speed (MAX_SPEED),
      .sat_s     (sat_s)
   );

   always_comb begin
      speed_d = op_en ? sat_s : speed_q;
      coast_d = '0;
      if ((state_q == IDLE) && !pedal)
         coast_d = (coast_q == COAST_LAST) ? '0 : coast_q + CW'(1);
   end

   // Cruise FSM and target; brake dominates everything.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      if (brake) begin
         state_d = IDLE;
      end else if (cruise_off) begin
         state_d = IDLE;
      end else if (cruise_set && (speed_q >= MIN_CRUISE)) begin
         state_d  = CRUISE;
         target_d = speed_q;
      end else if ((state_q == CRUISE) && (cruise_up ^ cruise_down)) begin
         target_d = step_target(target_q, cruise_up, CRUISE_STEP,
                                MIN_CRUISE, MAX_SPEED);
      end
   end

   assign adder.add_a   = speed_q;
   assign adder.add_b   = op_b;
   assign adder.add_sel = op_sel;
   assign adder.add_en  = op_en;

   assign speed    = speed_q;
   assign target   = target_q;
   assign cruising = (state_q == CRUISE);

endmodule

// File: tb/tb_cruise_speed_regulator.sv
// Directed bench for cruise_speed_regulator with a
// behavioural 8-bit adder/subtractor on the bus.
module tb_cruise_speed_regulator;

   logic       clk;
   logic       rst_n;
   logic       throttle;
   logic       brake;
   logic       cruise_set;
   logic       cruise_off;
   logic       cruise_up;
   logic       cruise_down;
   logic [7:0] speed;
   logic [7:0] target;
   logic       cruising;

   logic       ovr;
   logic [7:0] ovr_s;
   logic       ovr_c;
   logic [8:0] sum;

   int npass;
   int ntot;

   cruise_speed_regulator_if bus ();

   cruise_speed_regulator dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .throttle    (throttle),
      .brake       (brake),
      .cruise_set  (cruise_set),
      .cruise_off  (cruise_off),
      .cruise_up   (cruise_up),
      .cruise_down (cruise_down),
      .adder       (bus),
      .speed       (speed),
      .target      (target),
      .cruising    (cruising)
   );

   // Adder model; ovr injects an arbitrary result.
   always_comb begin
      sum = '0;
      if (ovr)
         sum = {ovr_c, ovr_s};
      else if (bus.add_en && bus.add_sel)
         sum = {1'b0, bus.add_a} + {1'b0, ~bus.add_b} + 9'd1;
      else if (bus.add_en)
         sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};
   end

   assign bus.add_s    = sum[7:0];
   assign bus.add_cout = sum[8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      ntot++;
      if (got === exp)
         npass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      npass = 0;
      ntot  = 0;
      rst_n = 1'b0;
      throttle = 1'b1;
      brake = 1'b0;
      cruise_set = 1'b0;
      cruise_off = 1'b0;
      cruise_up = 1'b0;
      cruise_down = 1'b0;
      ovr = 1'b0;
      ovr_s = '0;
      ovr_c = 1'b0;
      settle();
      chk("rst_en", 32'(bus.add_en), 0);
      chk("rst_b", 32'(bus.add_b), 0);
      tick();
      tick();
      chk("rst_speed", 32'(speed), 0);
      chk("rst_target", 32'(target), 0);
      chk("rst_cruising", 32'(cruising), 0);

      rst_n = 1'b1;
      settle();
      chk("acc_en", 32'(bus.add_en), 1);
      chk("acc_b", 32'(bus.add_b), 2);
      chk("acc_sel", 32'(bus.add_sel), 0);
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("accel", 32'(speed), 32'(2 * i));
      end

      ovr = 1'b1;
      ovr_s = 8'd4;
      ovr_c = 1'b1;
      tick();
      chk("ovf_cout", 32'(speed), 200);
      ovr = 1'b0;

      throttle = 1'b0;
      brake = 1'b1;
      tick();
      chk("brake196", 32'(speed), 196);
      brake = 1'b0;
      throttle = 1'b1;
      tick();
      chk("acc198", 32'(speed), 198);
      tick();
      chk("acc200", 32'(speed), 200);
      tick();
      chk("acc_clamp", 32'(speed), 200);

      throttle = 1'b0;
      brake = 1'b1;
      repeat (49) tick();
      chk("brake_to4", 32'(speed), 4);
      brake = 1'b0;
      repeat (7) tick();
      chk("coast_hold4", 32'(speed), 4);
      tick();
      chk("coast_to3", 32'(speed), 3);

      brake = 1'b1;
      settle();
      chk("borrow_cout", 32'(bus.add_cout), 0);
      tick();
      chk("borrow_zero", 32'(speed), 0);
      brake = 1'b0;
      settle();
      for (int i = 0; i < 7; i++) begin
         chk("coast_en0", 32'(bus.add_en), 0);
         tick();
      end
      chk("coast_en1", 32'(bus.add_en), 1);
      tick();
      chk("coast_floor", 32'(speed), 0);

      throttle = 1'b1;
      repeat (30) tick();
      chk("acc60", 32'(speed), 60);
      throttle = 1'b0;
      cruise_set = 1'b1;
      tick();
      cruise_set = 1'b0;
      chk("set_cruising", 32'(cruising), 1);
      chk("set_target", 32'(target), 60);
      cruise_up = 1'b1;
      tick();
      chk("up65", 32'(target), 65);
      tick();
      chk("up70", 32'(target), 70);
      chk("ramp61", 32'(speed), 61);
      cruise_up = 1'b0;
      repeat (9) tick();
      chk("ramp70", 32'(speed), 70);
      settle();
      chk("hold_en", 32'(bus.add_en), 0);

      brake = 1'b1;
      tick();
      brake = 1'b0;
      chk("cbrake_speed", 32'(speed), 66);
      chk("cbrake_off", 32'(cruising), 0);
      chk("cbrake_tgt", 32'(target), 70);

      brake = 1'b1;
      repeat (12) tick();
      brake = 1'b0;
      throttle = 1'b1;
      tick();
      throttle = 1'b0;
      chk("slow20", 32'(speed), 20);
      cruise_set = 1'b1;
      tick();
      cruise_set = 1'b0;
      chk("lowset_off", 32'(cruising), 0);
      chk("lowset_tgt", 32'(target), 70);

      throttle = 1'b1;
      repeat (15) tick();
      throttle = 1'b0;
      chk("acc50", 32'(speed), 50);
      repeat (7) tick();
      chk("coast50", 32'(speed), 50);
      tick();
      chk("coast49", 32'(speed), 49);

      cruise_set = 1'b1;
      tick();
      cruise_set = 1'b0;
      chk("set49", 32'(target), 49);
      cruise_down = 1'b1;
      repeat (4) tick();
      chk("down_clamp", 32'(target), 30);
      tick();
      chk("down_floor", 32'(target), 30);
      cruise_up = 1'b1;
      tick();
      chk("updown", 32'(target), 30);
      cruise_down = 1'b0;
      cruise_off = 1'b1;
      tick();
      cruise_off = 1'b0;
      cruise_up = 1'b0;
      chk("off_up_cr", 32'(cruising), 0);
      chk("off_up_tgt", 32'(target), 30);
      chk("decay43", 32'(speed), 43);

      cruise_set = 1'b1;
      tick();
      cruise_set = 1'b0;
      chk("reset_pre", 32'(target), 43);
      rst_n = 1'b0;
      tick();
      chk("mid_speed", 32'(speed), 0);
      chk("mid_target", 32'(target), 0);
      chk("mid_cruising", 32'(cruising), 0);
      chk("mid_en", 32'(bus.add_en), 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
